// File: rtl/cr_axi4s_slv_fifo.sv
// cr_axi4s_slv_fifo
// AXI4-stream slave receive stage.  Upstream beats are absorbed into a
// show-ahead synchronous FIFO.  The FIFO is presented downstream as a head
// bus plus empty/aempty/used flags and a pop strobe (fifo_rd).
// Backpressure (axi4s_ib_tready) is registered and reflects the occupancy
// after the current edge.
// Optional statistics counters are enabled by defining the macro
// CR_AXI4S_SLV_FIFO_STATS_EN.  They add the ports stat_frames and stat_stalls.
module cr_axi4s_slv_fifo #(
    parameter int DATA_W     = 64,
    parameter int USER_W     = 2,
    parameter int TID_W      = 1,
    parameter int DEPTH      = 8,
    parameter int AEMPTY_THR = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        axi4s_ib_tvalid,
    output logic                        axi4s_ib_tready,
    input  logic                        axi4s_ib_tlast,
    input  logic [TID_W-1:0]            axi4s_ib_tid,
    input  logic [USER_W-1:0]           axi4s_ib_tuser,
    input  logic [DATA_W/8-1:0]         axi4s_ib_tstrb,
    input  logic [DATA_W-1:0]           axi4s_ib_tdata,
    input  logic                        fifo_rd,
    output logic                        fifo_out_tvalid,
    output logic                        fifo_out_tlast,
    output logic [TID_W-1:0]            fifo_out_tid,
    output logic [USER_W-1:0]           fifo_out_tuser,
    output logic [DATA_W/8-1:0]         fifo_out_tstrb,
    output logic [DATA_W-1:0]           fifo_out_tdata,
    output logic                        fifo_empty,
    output logic                        fifo_aempty,
    output logic [$clog2(DEPTH):0]      fifo_used,
    output logic                        fifo_err_udf
`ifdef CR_AXI4S_SLV_FIFO_STATS_EN
    ,
    output logic [31:0]                 stat_frames,
    output logic [31:0]                 stat_stalls
`endif
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + TID_W + USER_W + STRB_W + DATA_W;

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_THR);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);

    // Storage holds {tlast, tid, tuser, tstrb, tdata}; never reset.
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   used;
    logic [CNT_W-1:0]   used_next;
    logic               tready_q;
    logic               err_udf_q;
    logic               empty;
    logic               wr_en;
    logic               rd_en;
    logic [ENTRY_W-1:0] head;

    // A beat is taken only while the registered ready is high.  A pop is
    // honoured only when data is present; a pop while empty is just flagged.
    assign empty = (used == '0);
    assign wr_en = axi4s_ib_tvalid & tready_q;
    assign rd_en = fifo_rd & ~empty;

    // Next occupancy: a simultaneous write and read leaves it unchanged.
    always_comb begin
        used_next = used;
        case ({wr_en, rd_en})
            2'b10:   used_next = used + CNT_W'(1);
            2'b01:   used_next = used - CNT_W'(1);
            default: used_next = used;
        endcase
    end

    // Write the accepted beat into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {axi4s_ib_tlast, axi4s_ib_tid, axi4s_ib_tuser,
                            axi4s_ib_tstrb, axi4s_ib_tdata};
        end
    end

    // Pointers, occupancy, registered backpressure and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            tready_q  <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            used     <= used_next;
            tready_q <= (used_next < DEPTH_CNT);
            if (fifo_rd && empty) begin
                err_udf_q <= 1'b1;
            end
        end
    end

    // Show-ahead head entry, forced to zero whenever the FIFO is empty.
    assign head = mem[rd_ptr];

    assign {fifo_out_tlast, fifo_out_tid, fifo_out_tuser,
            fifo_out_tstrb, fifo_out_tdata} = empty ? '0 : head;

    assign fifo_out_tvalid = ~empty;
    assign fifo_empty      = empty;
    assign fifo_aempty     = (used <= AEMPTY_CNT);
    assign fifo_used       = used;
    assign fifo_err_udf    = err_udf_q;
    assign axi4s_ib_tready = tready_q;

`ifdef CR_AXI4S_SLV_FIFO_STATS_EN
    // Saturating counters for completed frames and upstream stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_stalls <= '0;
        end else begin
            if (wr_en && axi4s_ib_tlast && (stat_frames != '1)) begin
                stat_frames <= stat_frames + 32'd1;
            end
            if (axi4s_ib_tvalid && !tready_q && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cr_axi4s_slv_fifo.sv
// tb_cr_axi4s_slv_fifo
// Scoreboard bench for cr_axi4s_slv_fifo.  The driver holds each beat until
// it is accepted and then queues it as the expected FIFO content.  A monitor
// on the falling edge checks the flags and head bus against that queue and
// retires entries as the consumer pops them.
module tb_cr_axi4s_slv_fifo;

    localparam int DATA_W     = 64;
    localparam int USER_W     = 2;
    localparam int TID_W      = 1;
    localparam int DEPTH      = 8;
    localparam int AEMPTY_THR = 1;
    localparam int STRB_W     = DATA_W / 8;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              last;
        logic [TID_W-1:0]  id;
        logic [USER_W-1:0] user;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic              axi4s_ib_tvalid;
    logic              axi4s_ib_tready;
    logic              axi4s_ib_tlast;
    logic [TID_W-1:0]  axi4s_ib_tid;
    logic [USER_W-1:0] axi4s_ib_tuser;
    logic [STRB_W-1:0] axi4s_ib_tstrb;
    logic [DATA_W-1:0] axi4s_ib_tdata;
    logic              fifo_rd;
    logic              fifo_out_tvalid;
    logic              fifo_out_tlast;
    logic [TID_W-1:0]  fifo_out_tid;
    logic [USER_W-1:0] fifo_out_tuser;
    logic [STRB_W-1:0] fifo_out_tstrb;
    logic [DATA_W-1:0] fifo_out_tdata;
    logic              fifo_empty;
    logic              fifo_aempty;
    logic [CNT_W-1:0]  fifo_used;
    logic              fifo_err_udf;
`ifdef CR_AXI4S_SLV_FIFO_STATS_EN
    logic [31:0]       stat_frames;
    logic [31:0]       stat_stalls;
`endif

    cr_axi4s_slv_fifo #(
        .DATA_W     (DATA_W),
        .USER_W     (USER_W),
        .TID_W      (TID_W),
        .DEPTH      (DEPTH),
        .AEMPTY_THR (AEMPTY_THR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi4s_ib_tvalid (axi4s_ib_tvalid),
        .axi4s_ib_tready (axi4s_ib_tready),
        .axi4s_ib_tlast  (axi4s_ib_tlast),
        .axi4s_ib_tid    (axi4s_ib_tid),
        .axi4s_ib_tuser  (axi4s_ib_tuser),
        .axi4s_ib_tstrb  (axi4s_ib_tstrb),
        .axi4s_ib_tdata  (axi4s_ib_tdata),
        .fifo_rd         (fifo_rd),
        .fifo_out_tvalid (fifo_out_tvalid),
        .fifo_out_tlast  (fifo_out_tlast),
        .fifo_out_tid    (fifo_out_tid),
        .fifo_out_tuser  (fifo_out_tuser),
        .fifo_out_tstrb  (fifo_out_tstrb),
        .fifo_out_tdata  (fifo_out_tdata),
        .fifo_empty      (fifo_empty),
        .fifo_aempty     (fifo_aempty),
        .fifo_used       (fifo_used),
        .fifo_err_udf    (fifo_err_udf)
`ifdef CR_AXI4S_SLV_FIFO_STATS_EN
        ,
        .stat_frames     (stat_frames),
        .stat_stalls     (stat_stalls)
`endif
    );

    // Expected FIFO contents, oldest first.
    beat_t sb[$];

    int    vec_count = 0;
    int    err_count = 0;
    bit    exp_err   = 1'b0;
    bit    ready_live = 1'b0;
    int    mon_n;
    beat_t cur;
    bit    rdy;
    bit    accepted = 1'b0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mkBeat(input logic [DATA_W-1:0] d, input logic l);
        beat_t b;
        b.last = l;
        b.id   = '0;
        b.user = '0;
        b.strb = '1;
        b.data = d;
        return b;
    endfunction

    function automatic beat_t randBeat();
        beat_t b;
        b.last = 1'($urandom);
        b.id   = TID_W'($urandom);
        b.user = USER_W'($urandom);
        b.strb = STRB_W'($urandom);
        b.data = {$urandom, $urandom};
        return b;
    endfunction

    // One cycle of stimulus, entered and left 1 time unit after a rising
    // edge.  A beat that was not accepted stays on the bus unchanged.
    task automatic applyStimulus(input bit new_valid, input beat_t nb, input bit rd);
        if (!axi4s_ib_tvalid || accepted) begin
            cur             = nb;
            axi4s_ib_tvalid = new_valid;
            axi4s_ib_tlast  = nb.last;
            axi4s_ib_tid    = nb.id;
            axi4s_ib_tuser  = nb.user;
            axi4s_ib_tstrb  = nb.strb;
            axi4s_ib_tdata  = nb.data;
        end
        fifo_rd = rd;
        @(negedge clk);
        rdy = axi4s_ib_tready;
        @(posedge clk);
        #1;
        accepted = axi4s_ib_tvalid && rdy;
        if (accepted) sb.push_back(cur);
    endtask

    // Monitor: compare flags and head bus with the scoreboard, then retire
    // the head entry if the consumer pops it at the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_tready", axi4s_ib_tready, 0);
            checkOutput("rst_empty", fifo_empty, 1);
            checkOutput("rst_aempty", fifo_aempty, 1);
            checkOutput("rst_used", fifo_used, 0);
            checkOutput("rst_err", fifo_err_udf, 0);
            checkOutput("rst_tvalid", fifo_out_tvalid, 0);
            checkOutput("rst_tdata", fifo_out_tdata, 0);
            ready_live = 1'b0;
            exp_err    = 1'b0;
        end else begin
            mon_n = sb.size();
            checkOutput("tready", axi4s_ib_tready, ready_live ? (mon_n < DEPTH) : 0);
            checkOutput("empty", fifo_empty, mon_n == 0);
            checkOutput("aempty", fifo_aempty, mon_n <= AEMPTY_THR);
            checkOutput("used", fifo_used, 64'(mon_n));
            checkOutput("out_tvalid", fifo_out_tvalid, mon_n != 0);
            checkOutput("err_udf", fifo_err_udf, exp_err);
            if (mon_n > 0) begin
                checkOutput("head_tdata", fifo_out_tdata, sb[0].data);
                checkOutput("head_tlast", fifo_out_tlast, sb[0].last);
                checkOutput("head_tid", fifo_out_tid, sb[0].id);
                checkOutput("head_tuser", fifo_out_tuser, sb[0].user);
                checkOutput("head_tstrb", fifo_out_tstrb, sb[0].strb);
            end else begin
                checkOutput("idle_tdata", fifo_out_tdata, 0);
                checkOutput("idle_tlast", fifo_out_tlast, 0);
                checkOutput("idle_tid", fifo_out_tid, 0);
                checkOutput("idle_tuser", fifo_out_tuser, 0);
                checkOutput("idle_tstrb", fifo_out_tstrb, 0);
            end
            if (fifo_rd) begin
                if (mon_n > 0) void'(sb.pop_front());
                else exp_err = 1'b1;
            end
            ready_live = 1'b1;
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        rst_n           = 1'b0;
        axi4s_ib_tvalid = 1'b0;
        axi4s_ib_tlast  = 1'b0;
        axi4s_ib_tid    = '0;
        axi4s_ib_tuser  = '0;
        axi4s_ib_tstrb  = '0;
        axi4s_ib_tdata  = '0;
        fifo_rd         = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset, then a single beat that is visible next cycle.
        applyStimulus(0, mkBeat(0, 0), 0);
        applyStimulus(0, mkBeat(0, 0), 0);
        applyStimulus(1, mkBeat(64'hA5, 1), 0);
        applyStimulus(0, mkBeat(0, 0), 0);
        applyStimulus(0, mkBeat(0, 0), 1);

        // Fill to DEPTH, then hold a further beat against backpressure.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, mkBeat(64'(i), 0), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, mkBeat(64'(DEPTH), 1), 0);

        // Pop one at full; the held beat goes in, then drain across the wrap.
        applyStimulus(1, mkBeat(64'hDEAD, 0), 1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, mkBeat(0, 0), 1);
        applyStimulus(0, mkBeat(0, 0), 0);

        // Streaming at occupancy 1 with a pop every cycle.
        applyStimulus(1, mkBeat(64'd100, 0), 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, mkBeat(64'(101 + i), i[0]), 1);
        applyStimulus(0, mkBeat(0, 0), 1);

        // Pop while empty raises the sticky underflow flag.
        applyStimulus(0, mkBeat(0, 0), 1);
        applyStimulus(1, mkBeat(64'h55, 1), 0);
        applyStimulus(0, mkBeat(0, 0), 0);

        // Asynchronous reset in mid-cycle clears everything immediately.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_tready", axi4s_ib_tready, 0);
        checkOutput("async_empty", fifo_empty, 1);
        checkOutput("async_used", fifo_used, 0);
        checkOutput("async_err", fifo_err_udf, 0);
        checkOutput("async_tvalid", fifo_out_tvalid, 0);
        checkOutput("async_tdata", fifo_out_tdata, 0);
        sb.delete();
        axi4s_ib_tvalid = 1'b0;
        fifo_rd         = 1'b0;
        accepted        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(0, mkBeat(0, 0), 0);

        // Random traffic with phases biased towards full, empty and balanced.
        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(0, 99) < 80, randBeat(), $urandom_range(0, 99) < 30);
        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(0, 99) < 35, randBeat(), $urandom_range(0, 99) < 75);
        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(0, 99) < 60, randBeat(), $urandom_range(0, 99) < 55);

        applyStimulus(0, mkBeat(0, 0), 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/cr_axi4s_slv_fifo.md
Name: cr_axi4s_slv_fifo

Overview:
- AXI4-stream slave receive stage with an internal show-ahead synchronous FIFO.
- Sits directly upstream of the AXI4-stream master output stage and feeds it through a FIFO-style read interface: head bus, empty, aempty and rd.
- Converts the upstream tvalid/tready handshake into the FIFO-style interface.
- Absorbs upstream bursts and provides registered backpressure.

Parameters:
- DATA_W, 64: tdata width; tstrb width is DATA_W/8.
- USER_W, 2: tuser width.
- TID_W, 1: tid width.
- DEPTH, 8: FIFO entries; power of 2, minimum 4.
- AEMPTY_THR, 1: aempty asserted when occupancy <= AEMPTY_THR; range 0..DEPTH-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- axi4s_ib_tvalid  in  1  upstream beat valid
- axi4s_ib_tready  out  1  backpressure to upstream; registered
- axi4s_ib_tlast  in  1  end of frame
- axi4s_ib_tid  in  TID_W  stream id
- axi4s_ib_tuser  in  USER_W  sideband
- axi4s_ib_tstrb  in  DATA_W/8  byte strobes
- axi4s_ib_tdata  in  DATA_W  payload
- fifo_rd  in  1  pop head entry
- fifo_out_tvalid  out  1  equals ~fifo_empty
- fifo_out_tlast  out  1  head tlast, or 0 when empty
- fifo_out_tid  out  TID_W  head tid, or 0 when empty
- fifo_out_tuser  out  USER_W  head tuser, or 0 when empty
- fifo_out_tstrb  out  DATA_W/8  head tstrb, or 0 when empty
- fifo_out_tdata  out  DATA_W  head tdata, or 0 when empty
- fifo_empty  out  1  occupancy == 0
- fifo_aempty  out  1  occupancy <= AEMPTY_THR
- fifo_used  out  $clog2(DEPTH)+1  current occupancy
- fifo_err_udf  out  1  sticky: fifo_rd asserted while empty

Behaviour:
- Reset: asynchronous, active-low; clock clk.
  - Pointers and occupancy clear to 0.
  - axi4s_ib_tready=0 during reset; goes to 1 on the first clk edge after deassertion.
  - fifo_empty=1, fifo_aempty=1, fifo_used=0, fifo_err_udf=0, all fifo_out_* =0.
  - Storage RAM contents need no reset.
- Write: occurs when axi4s_ib_tvalid & axi4s_ib_tready at a clk edge. The beat {tlast, tid, tuser, tstrb, tdata} is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- Read: occurs when fifo_rd & ~fifo_empty; rd_ptr increments modulo DEPTH.
- fifo_rd while empty is ignored (no pointer change) and sets fifo_err_udf. fifo_err_udf clears only on reset.
- Show-ahead: fifo_out_* reflect the head entry combinationally from storage and rd_ptr.
  - A beat written at edge N is visible on fifo_out at cycle N+1.
  - Write-to-output latency is 1 cycle.
- Occupancy: used_next = used + wr - rd.
  - Simultaneous write and read leaves used unchanged; both pointers advance.
  - Simultaneous read and write at used==1 keeps fifo_empty=0, and the head becomes the new beat.
- tready is a register loaded each cycle with (used_next < DEPTH).
  - At full, tready=0, so no write can occur when full. No overflow is possible.
  - A pop at full re-asserts tready the following cycle. One bubble at full is accepted.
- Flags fifo_empty, fifo_aempty and fifo_used derive from the registered occupancy and update on the edge after the causing write or read.
- Pointer width is $clog2(DEPTH); wrap from DEPTH-1 to 0 is required. Occupancy width is one bit wider.
- Consumer contract: the downstream master may pop any cycle fifo_empty=0. fifo_out_tvalid lets that stage copy the bus verbatim.

Optional Feature:
- Macro: CR_AXI4S_SLV_FIFO_STATS_EN.
- When defined, two output ports are added:
  - stat_frames (32 bits): increments on each accepted write with tlast=1.
  - stat_stalls (32 bits): increments on each cycle with axi4s_ib_tvalid=1 and axi4s_ib_tready=0.
  - Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then tvalid=0 -> cycle 1 after reset shows tready=1, empty=1, aempty=1, used=0, fifo_out_* all 0.
- Write one beat tdata=0xA5, tlast=1 with fifo_rd=0 -> next cycle fifo_out_tvalid=1, tdata=0xA5, tlast=1, used=1, empty=0, aempty=1 (AEMPTY_THR=1).
- Back-to-back 8 writes (0..7) with DEPTH=8 and no reads -> used reaches 8; tready=0 the cycle after the 8th write; the 9th beat held on the bus is not accepted.
- From full, pop one -> tready=1 next cycle; held beat 8 is written; reading all beats then yields order 0..8 with wrap-around correct.
- Continuous write with fifo_rd=1 every cycle at used=1 -> used stays 1; output tracks each beat 1 cycle late; tready stays 1.
- fifo_rd=1 while empty -> pointers unchanged, fifo_err_udf=1 and stays 1 until rst_n asserted mid-run, which clears all state asynchronously.
